td4_core: RTL and testbench



---
 rtl/td4_pkg.sv | 35 +++
 rtl/td4_decode.sv | 73 +++++++
 rtl/td4_core.sv | 73 +++++++
 tb/tb_td4_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// td4 shared types: opcodes, ALU source select and write destination.
// Imported by the decoder and the core.
package td4_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_A,
    SRC_B,
    SRC_IN,
    SRC_ZERO
  } src_e;

  typedef enum logic [2:0] {
    DST_A,
    DST_B,
    DST_OUT,
    DST_PC,
    DST_NONE
  } dst_e;

endpackage

// File: rtl/td4_decode.sv
// td4 instruction decoder: opcode plus carry flag to
// ALU source, write destination and PC load.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       carry,
  output src_e       src,
  output dst_e       dst,
  output logic       load_pc
);

  always_comb begin
    src = SRC_ZERO;
    dst = DST_NONE;
    unique case (1'b1)
      (op == OP_ADD_A): begin
        src = SRC_A;
        dst = DST_A;
      end
      (op == OP_MOV_AB): begin
        src = SRC_B;
        dst = DST_A;
      end
      (op == OP_IN_A): begin
        src = SRC_IN;
        dst = DST_A;
      end
      (op == OP_MOV_A): begin
        src = SRC_ZERO;
        dst = DST_A;
      end
      (op == OP_MOV_BA): begin
        src = SRC_A;
        dst = DST_B;
      end
      (op == OP_ADD_B): begin
        src = SRC_B;
        dst = DST_B;
      end
      (op == OP_IN_B): begin
        src = SRC_IN;
        dst = DST_B;
      end
      (op == OP_MOV_B): begin
        src = SRC_ZERO;
        dst = DST_B;
      end
      (op == OP_OUT_B): begin
        src = SRC_B;
        dst = DST_OUT;
      end
      (op == OP_OUT_IM): begin
        src = SRC_ZERO;
        dst = DST_OUT;
      end
      (op == OP_JNC): begin
        src = SRC_ZERO;
        dst = carry ? DST_NONE : DST_PC;
      end
      (op == OP_JMP): begin
        src = SRC_ZERO;
        dst = DST_PC;
      end
      default: begin
        src = SRC_ZERO;
        dst = DST_NONE;
      end
    endcase
    load_pc = (dst == DST_PC);
  end

endmodule

// File: rtl/td4_core.sv
// td4 single-cycle core: PC, A, B, carry and output latch.
// Executes the ROM word at rom_addr on every enabled edge.
module td4_core
  import td4_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry
);

  logic [3:0] pc;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] out_q;
  logic       c_q;

  src_e       src;
  dst_e       dst;
  logic       load_pc;
  logic [3:0] src_val;
  logic [4:0] sum;

  td4_decode u_decode (
    .op      (rom_data[7:4]),
    .carry   (c_q),
    .src     (src),
    .dst     (dst),
    .load_pc (load_pc)
  );

  always_comb begin
    src_val = 4'd0;
    case (src)
      SRC_A:   src_val = a_q;
      SRC_B:   src_val = b_q;
      SRC_IN:  src_val = in_port;
      default: src_val = 4'd0;
    endcase
  end

  // Carry always takes the adder's top bit, even for moves and jumps.
  assign sum = {1'b0, src_val} + {1'b0, rom_data[3:0]};

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pc    <= 4'd0;
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      out_q <= 4'd0;
      c_q   <= 1'b0;
    end else if (en) begin
      c_q <= sum[4];
      pc  <= load_pc ? sum[3:0] : pc + 4'd1;
      if (dst == DST_A)   a_q   <= sum[3:0];
      if (dst == DST_B)   b_q   <= sum[3:0];
      if (dst == DST_OUT) out_q <= sum[3:0];
    end
  end

  assign rom_addr = pc;
  assign out_port = out_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign carry    = c_q;

endmodule

// File: tb/tb_td4_core.sv
// Scoreboard bench for td4_core: directed steps push expected
// state, a monitor pops and compares one edge later.
module tb_td4_core;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;

  logic [7:0] instr;
  logic [7:0] rom [16];
  logic       rom_mode;

  typedef struct {
    string      name;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] o;
  } exp_t;

  exp_t       q[$];
  logic [3:0] oq[$];
  exp_t       e;
  logic [3:0] eo;
  logic [3:0] prev_out;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mode ? rom[rom_addr] : instr;

  td4_core dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .carry    (carry)
  );

  // Monitor: state is checked 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (rom_addr !== e.pc || reg_a !== e.a || reg_b !== e.b ||
          carry !== e.c || out_port !== e.o) begin
        errors++;
        $display("FAIL %s: got pc=%h a=%h b=%h c=%b out=%h, want pc=%h a=%h b=%h c=%b out=%h",
                 e.name, rom_addr, reg_a, reg_b, carry, out_port,
                 e.pc, e.a, e.b, e.c, e.o);
      end
    end
    if (rom_mode && out_port !== prev_out) begin
      checks++;
      if (oq.size() == 0) begin
        errors++;
        $display("FAIL prog_out_extra: got out=%h, want no change", out_port);
      end else begin
        eo = oq.pop_front();
        if (out_port !== eo) begin
          errors++;
          $display("FAIL prog_out_seq: got out=%h, want %h", out_port, eo);
        end
      end
    end
    prev_out = out_port;
  end

  task automatic step(input string nm, input logic [7:0] ins,
                      input logic [3:0] inp, input logic e_in,
                      input logic rn, input logic [3:0] pc,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic c, input logic [3:0] o);
    exp_t x;
    @(posedge clk);
    #2;
    instr   = ins;
    in_port = inp;
    en      = e_in;
    n_reset = rn;
    x.name = nm;
    x.pc = pc;
    x.a = a;
    x.b = b;
    x.c = c;
    x.o = o;
    q.push_back(x);
  endtask

  initial begin
    rom_mode = 1'b0;
    n_reset  = 1'b0;
    en       = 1'b0;
    instr    = 8'h00;
    in_port  = 4'h0;
    prev_out = 4'h0;

    //         name        instr  in    en  rn  pc  a     b     c   out
    step("reset",     8'h3F, 4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0);
    step("out_im",    8'hB7, 4'h0, 1, 1, 4'h1, 4'h0, 4'h0, 0, 4'h7);
    step("mov_a_f",   8'h3F, 4'h0, 1, 1, 4'h2, 4'hF, 4'h0, 0, 4'h7);
    step("add_ovf",   8'h01, 4'h0, 1, 1, 4'h3, 4'h0, 4'h0, 1, 4'h7);
    step("jnc_nt",    8'hE1, 4'h0, 1, 1, 4'h4, 4'h0, 4'h0, 0, 4'h7);
    step("jnc_t",     8'hE8, 4'h0, 1, 1, 4'h8, 4'h0, 4'h0, 0, 4'h7);
    step("mov_b_im",  8'h75, 4'h0, 1, 1, 4'h9, 4'h0, 4'h5, 0, 4'h7);
    step("mov_a_b",   8'h10, 4'h0, 1, 1, 4'hA, 4'h5, 4'h5, 0, 4'h7);
    step("in_b",      8'h60, 4'hA, 1, 1, 4'hB, 4'h5, 4'hA, 0, 4'h7);
    step("out_b",     8'h90, 4'h3, 1, 1, 4'hC, 4'h5, 4'hA, 0, 4'hA);
    step("add_b_ovf", 8'h57, 4'h0, 1, 1, 4'hD, 4'h5, 4'h1, 1, 4'hA);
    step("mov_b_a",   8'h40, 4'h0, 1, 1, 4'hE, 4'h5, 4'h5, 0, 4'hA);
    step("in_a",      8'h20, 4'h3, 1, 1, 4'hF, 4'h3, 4'h5, 0, 4'hA);
    step("pc_wrap",   8'h0F, 4'h0, 1, 1, 4'h0, 4'h2, 4'h5, 1, 4'hA);
    step("undef_8",   8'h8F, 4'hF, 1, 1, 4'h1, 4'h2, 4'h5, 0, 4'hA);
    step("add_c_set", 8'h0F, 4'h0, 1, 1, 4'h2, 4'h1, 4'h5, 1, 4'hA);
    for (int i = 0; i < 10; i++)
      step("en_hold", 8'hFF, 4'hF, 0, 1, 4'h2, 4'h1, 4'h5, 1, 4'hA);
    step("jnc_c1",    8'hE9, 4'h0, 1, 1, 4'h3, 4'h1, 4'h5, 0, 4'hA);
    step("undef_a",   8'hA7, 4'h0, 1, 1, 4'h4, 4'h1, 4'h5, 0, 4'hA);
    step("undef_c",   8'hC7, 4'h0, 1, 1, 4'h5, 4'h1, 4'h5, 0, 4'hA);
    step("undef_d",   8'hD7, 4'h0, 1, 1, 4'h6, 4'h1, 4'h5, 0, 4'hA);
    step("jmp_f",     8'hFF, 4'h0, 1, 1, 4'hF, 4'h1, 4'h5, 0, 4'hA);
    for (int i = 0; i < 3; i++)
      step("jmp_loop", 8'hFF, 4'h0, 1, 1, 4'hF, 4'h1, 4'h5, 0, 4'hA);
    step("reset_en",  8'h3F, 4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0);
    step("reset_hold",8'h75, 4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0);
    step("post_rst",  8'h75, 4'h0, 1, 1, 4'h1, 4'h0, 4'h5, 0, 4'h0);
    step("final_rst", 8'h00, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0);

    @(posedge clk);
    #2;
    en = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    // Timer program from ROM
    rom[0]  = 8'hB7; rom[1]  = 8'h01; rom[2]  = 8'hE1; rom[3]  = 8'h01;
    rom[4]  = 8'hE3; rom[5]  = 8'hB6; rom[6]  = 8'h01; rom[7]  = 8'hE6;
    rom[8]  = 8'h01; rom[9]  = 8'hE8; rom[10] = 8'hB0; rom[11] = 8'hB4;
    rom[12] = 8'h01; rom[13] = 8'hEA; rom[14] = 8'hB8; rom[15] = 8'hFF;
    oq.push_back(4'h7);
    oq.push_back(4'h6);
    for (int i = 0; i < 16; i++) begin
      oq.push_back(4'h0);
      oq.push_back(4'h4);
    end
    oq.push_back(4'h8);

    rom_mode = 1'b1;
    n_reset  = 1'b1;
    en       = 1'b1;
    for (int i = 0; i < 400 && !(oq.size() == 0 && rom_addr == 4'hF); i++)
      @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (oq.size() != 0) begin
      errors++;
      $display("FAIL prog_timeout: got %0d outputs missing, want 0", oq.size());
    end
    checks++;
    if (rom_addr !== 4'hF) begin
      errors++;
      $display("FAIL prog_end_pc: got %h, want f", rom_addr);
    end
    checks++;
    if (out_port !== 4'h8) begin
      errors++;
      $display("FAIL prog_end_out: got %h, want 8", out_port);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
